fifo_ctrl: RTL and testbench

Control unit for the 8-entry, 32-bit FIFO. It owns the head/tail pointers and the occupancy count, and it accepts or rejects push/pop requests. It drives the register-file write strobe and address, plus the read-mux enable and select. The storage array and the 8:1 read mux are separate blocks and hold no control state.

---
 rtl/fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: head/tail pointers, occupancy count and strobe decode for an 8x32 FIFO.
// The storage array and the 8:1 read mux are external and stateless.
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          we,
    output logic [AW-1:0] wr_addr,
    output logic          re,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] data_count,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5
    } state_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [AW-1:0] ZERO_PTR = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    // Next-state decode; simultaneous push and pop are both dropped.
    always_comb begin
        state_d   = NO_OP;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        if (wr_en && !rd_en) begin
            if (count_q != FULL_CNT) begin
                state_d   = WRITE;
                wr_addr_d = tail_q;
                tail_d    = tail_q + ONE_PTR;
                count_d   = count_q + ONE_CNT;
            end else begin
                state_d   = WR_ERROR;
            end
        end else if (rd_en && !wr_en) begin
            if (count_q != ZERO_CNT) begin
                state_d   = READ;
                rd_addr_d = head_q;
                head_d    = head_q + ONE_PTR;
                count_d   = count_q - ONE_CNT;
            end else begin
                state_d   = RD_ERROR;
            end
        end else begin
            state_d = NO_OP;
        end
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            head_q    <= ZERO_PTR;
            tail_q    <= ZERO_PTR;
            count_q   <= ZERO_CNT;
            wr_addr_q <= ZERO_PTR;
            rd_addr_q <= ZERO_PTR;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Strobe and flag decode from the registered state.
    always_comb begin
        we      = 1'b0;
        wr_addr = ZERO_PTR;
        re      = 1'b0;
        rd_addr = ZERO_PTR;
        wr_ack  = 1'b0;
        wr_err  = 1'b0;
        rd_ack  = 1'b0;
        rd_err  = 1'b0;
        case (state_q)
            WRITE: begin
                we      = 1'b1;
                wr_addr = wr_addr_q;
                wr_ack  = 1'b1;
            end
            WR_ERROR: begin
                wr_err  = 1'b1;
            end
            READ: begin
                re      = 1'b1;
                rd_addr = rd_addr_q;
                rd_ack  = 1'b1;
            end
            RD_ERROR: begin
                rd_err  = 1'b1;
            end
            default: begin
                we      = 1'b0;
                re      = 1'b0;
            end
        endcase
    end

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == ZERO_CNT);
    assign data_count = count_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl with a behavioural storage array and read mux.
// Expected outputs are queued as each request is driven and popped one cycle later.
module tb_fifo_ctrl;

    typedef struct packed {
        logic       we;
        logic [2:0] wa;
        logic       re;
        logic [2:0] ra;
        logic       full;
        logic       empty;
        logic [3:0] cnt;
        logic       wack;
        logic       werr;
        logic       rack;
        logic       rerr;
    } ovec_t;

    typedef struct {
        ovec_t       v;
        logic [31:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [2:0] wr_addr, rd_addr;
    logic [3:0] data_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          m_count = 0;
    logic [2:0]  m_head = 3'd0;
    logic [2:0]  m_tail = 3'd0;
    logic [31:0] dq[$];
    exp_t        exp_q[$];
    exp_t        exp_cur;
    logic [31:0] mem [8];
    ovec_t       obs;
    logic [31:0] mux;

    fifo_ctrl #(.DEPTH(8), .AW(3), .CW(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .we(we), .wr_addr(wr_addr), .re(re), .rd_addr(rd_addr),
        .full(full), .empty(empty), .data_count(data_count),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // Predict one cycle, drive it, then sample outputs and model the array/mux.
    task automatic apply(input logic w, input logic r, input logic rst);
        exp_t        e;
        logic [31:0] wd;
        e.v = '0;
        e.d = 32'd0;
        wd  = $urandom;
        if (rst) begin
            m_count = 0;
            m_head  = 3'd0;
            m_tail  = 3'd0;
            dq.delete();
        end else if (w && !r) begin
            if (m_count < 8) begin
                e.v.we = 1'b1; e.v.wa = m_tail; e.v.wack = 1'b1;
                m_tail = m_tail + 3'd1;
                m_count++;
                dq.push_back(wd);
            end else begin
                e.v.werr = 1'b1;
            end
        end else if (r && !w) begin
            if (m_count > 0) begin
                e.v.re = 1'b1; e.v.ra = m_head; e.v.rack = 1'b1;
                e.d = dq.pop_front();
                m_head = m_head + 3'd1;
                m_count--;
            end else begin
                e.v.rerr = 1'b1;
            end
        end
        e.v.cnt   = 4'(m_count);
        e.v.full  = (m_count == 8);
        e.v.empty = (m_count == 0);
        exp_q.push_back(e);
        reset = rst; wr_en = w; rd_en = r;
        @(posedge clk);
        #1;
        obs = {we, wr_addr, re, rd_addr, full, empty, data_count, wr_ack, wr_err, rd_ack, rd_err};
        if (we) mem[wr_addr] = wd;
        mux = re ? mem[rd_addr] : 32'd0;
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, (i < 2) ? 1'b1 : 1'b0);
            exp_cur = exp_q.pop_front();
            vectors++;
            if (obs !== exp_cur.v) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, obs, exp_cur.v);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, 1'b0, 1'b0);
            exp_cur = exp_q.pop_front();
            vectors++;
            if (obs !== exp_cur.v) begin
                miscompares++;
                $display("FAIL fill[%0d]: got %h want %h", i, obs, exp_cur.v);
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            exp_cur = exp_q.pop_front();
            vectors++;
            if (obs !== exp_cur.v) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h want %h", i, obs, exp_cur.v);
            end
            vectors++;
            if (mux !== exp_cur.d) begin
                miscompares++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, mux, exp_cur.d);
            end
        end
    endtask

    task automatic test_wrap();
        logic w;
        for (int i = 0; i < 23; i++) begin
            w = (i >= 1 && i < 7) || (i >= 13 && i < 18);
            apply(w, (i == 0) ? 1'b0 : !w, (i == 0) ? 1'b1 : 1'b0);
            exp_cur = exp_q.pop_front();
            vectors++;
            if (obs !== exp_cur.v) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h want %h", i, obs, exp_cur.v);
            end
            vectors++;
            if (mux !== exp_cur.d) begin
                miscompares++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, mux, exp_cur.d);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic w, r;
        for (int i = 0; i < 11; i++) begin
            w = (i >= 1 && i <= 6);
            r = (i == 4 || i == 5 || i >= 7);
            apply(w, r, (i == 0) ? 1'b1 : 1'b0);
            exp_cur = exp_q.pop_front();
            vectors++;
            if (obs !== exp_cur.v) begin
                miscompares++;
                $display("FAIL simultaneous[%0d]: got %h want %h", i, obs, exp_cur.v);
            end
            vectors++;
            if (mux !== exp_cur.d) begin
                miscompares++;
                $display("FAIL simultaneous_data[%0d]: got %h want %h", i, mux, exp_cur.d);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            apply((i >= 1), 1'b0, (i == 0 || i == 6) ? 1'b1 : 1'b0);
            exp_cur = exp_q.pop_front();
            vectors++;
            if (obs !== exp_cur.v) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got %h want %h", i, obs, exp_cur.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
